ritc_dac_servo: RTL and testbench

- Closed-loop threshold servo feeding the servo port of the RITC dual DAC block.
- Consumes per-RITC comparator rate samples and compares each against a programmable target with a deadband.
- Steps a 12-bit servo DAC value per RITC, writes it via the servo_* write strobe, then requests a DAC reload and waits for the loader to finish.
- Exposes a pause/paused handshake so software can safely write other DAC registers.

---
 rtl/ritc_dac_servo.sv | 231 +++++++++++++++++++++++
 tb/tb_ritc_dac_servo.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ritc_dac_servo.sv
// Threshold servo for the RITC dual DAC: steps a 12-bit value per RITC from rate samples and requests reloads.
// Define RITC_DAC_SERVO_PROPORTIONAL_EN for an error-proportional step instead of the fixed reg 2 step.
`timescale 1ns/1ps
module ritc_dac_servo #(
  parameter int RATE_BITS    = 16,
  parameter int DAC_BITS     = 12,
  parameter int INIT_VALUE   = 2048,
  parameter int DEFAULT_STEP = 1,
  parameter int BUSY_TIMEOUT = 15,
  parameter int GAIN_SHIFT   = 4,
  parameter int MAX_STEP     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rate_valid_i,
  input  logic                 rate_sel_i,
  input  logic [RATE_BITS-1:0] rate_i,
  input  logic                 user_sel_i,
  input  logic                 user_wr_i,
  input  logic [1:0]           user_addr_i,
  input  logic [31:0]          user_dat_i,
  output logic [31:0]          user_dat_o,
  input  logic                 loader_busy_i,
  output logic                 servo_addr_o,
  output logic                 servo_wr_o,
  output logic                 servo_update_o,
  output logic [DAC_BITS-1:0]  servo_o
);

  // state   | meaning
  // IDLE    | waiting for an accepted rate sample
  // CALC    | compare against target, compute new value
  // WRITE   | servo_wr_o strobe into DAC BRAM
  // UPDATE  | servo_update_o reload request
  // WAIT_HI | waiting for loader busy to rise (bounded)
  // WAIT_LO | waiting for loader busy to fall
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALC    = 3'd1,
    WRITE   = 3'd2,
    UPDATE  = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
  } state_t;

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_t               state;
  logic [1:0]           en;
  logic                 pause;
  logic                 dropped;
  logic                 timeout;
  logic [RATE_BITS-1:0] target0, target1, deadband;
  logic [DAC_BITS-1:0]  value0, value1;
  logic                 lat_sel;
  logic [RATE_BITS-1:0] lat_rate, lat_target;
  logic [CNT_W-1:0]     busy_cnt;
`ifndef RITC_DAC_SERVO_PROPORTIONAL_EN
  logic [DAC_BITS-1:0]  step;
`endif

  logic                 wr_en, preset_req, accept_ok, accept, drop, paused;
  logic [RATE_BITS:0]   err_raw, abs_err;
  logic                 in_band;
  logic [DAC_BITS-1:0]  step_eff, cur, up_val, dn_val, next_val;
  logic [DAC_BITS:0]    sum;
  logic                 unused_ok;

  assign unused_ok  = &{1'b0, user_dat_i};
  assign wr_en      = user_sel_i & user_wr_i;
  assign preset_req = wr_en && (user_addr_i == 2'd3) && (state == IDLE);
  assign accept_ok  = rate_valid_i && (state == IDLE) && !pause && en[rate_sel_i];
  // A same-cycle preset beats the sample so the preset value is never stepped over.
  assign accept     = accept_ok && !preset_req;
  assign drop       = rate_valid_i && ((state != IDLE) || (accept_ok && preset_req));
  assign paused     = pause && (state == IDLE);

  assign err_raw = {1'b0, lat_rate} - {1'b0, lat_target};
  assign abs_err = err_raw[RATE_BITS] ? (~err_raw + 1'b1) : err_raw;
  assign in_band = abs_err <= {1'b0, deadband};

`ifdef RITC_DAC_SERVO_PROPORTIONAL_EN
  logic [RATE_BITS:0] shifted;
  assign shifted = abs_err >> GAIN_SHIFT;
  always_comb begin
    step_eff = DAC_BITS'(shifted);
    if (shifted > (RATE_BITS+1)'(MAX_STEP)) step_eff = DAC_BITS'(MAX_STEP);
    else if (shifted == '0)                 step_eff = DAC_BITS'(1);
  end
`else
  assign step_eff = step;
`endif

  assign cur      = lat_sel ? value1 : value0;
  assign sum      = {1'b0, cur} + {1'b0, step_eff};
  assign up_val   = sum[DAC_BITS] ? '1 : sum[DAC_BITS-1:0];
  assign dn_val   = (step_eff > cur) ? '0 : cur - step_eff;
  assign next_val = err_raw[RATE_BITS] ? dn_val : up_val;

  always_comb begin
    user_dat_o = '0;
    case (user_addr_i)
      2'd0: begin
        user_dat_o[1:0] = en;
        user_dat_o[2]   = pause;
        user_dat_o[3]   = paused;
        user_dat_o[4]   = dropped;
        user_dat_o[5]   = timeout;
        user_dat_o[8:6] = state;
      end
      2'd1: begin
        user_dat_o[RATE_BITS-1:0]  = target0;
        user_dat_o[16 +: RATE_BITS] = target1;
      end
      2'd2: begin
        user_dat_o[RATE_BITS-1:0] = deadband;
`ifndef RITC_DAC_SERVO_PROPORTIONAL_EN
        user_dat_o[16 +: DAC_BITS] = step;
`endif
      end
      default: begin
        user_dat_o[DAC_BITS-1:0]   = value0;
        user_dat_o[16 +: DAC_BITS] = value1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state          <= IDLE;
      en             <= '0;
      pause          <= 1'b0;
      dropped        <= 1'b0;
      timeout        <= 1'b0;
      target0        <= '0;
      target1        <= '0;
      deadband       <= '0;
`ifndef RITC_DAC_SERVO_PROPORTIONAL_EN
      step           <= DAC_BITS'(DEFAULT_STEP);
`endif
      value0         <= DAC_BITS'(INIT_VALUE);
      value1         <= DAC_BITS'(INIT_VALUE);
      lat_sel        <= 1'b0;
      lat_rate       <= '0;
      lat_target     <= '0;
      busy_cnt       <= '0;
      servo_addr_o   <= 1'b0;
      servo_wr_o     <= 1'b0;
      servo_update_o <= 1'b0;
      servo_o        <= '0;
    end else begin
      servo_wr_o     <= 1'b0;
      servo_update_o <= 1'b0;

      if (wr_en) begin
        case (user_addr_i)
          2'd0: begin
            en    <= user_dat_i[1:0];
            pause <= user_dat_i[2];
            if (user_dat_i[4]) dropped <= 1'b0;
            if (user_dat_i[5]) timeout <= 1'b0;
          end
          2'd1: begin
            target0 <= user_dat_i[RATE_BITS-1:0];
            target1 <= user_dat_i[16 +: RATE_BITS];
          end
          2'd2: begin
            deadband <= user_dat_i[RATE_BITS-1:0];
`ifndef RITC_DAC_SERVO_PROPORTIONAL_EN
            step     <= user_dat_i[16 +: DAC_BITS];
`endif
          end
          default: begin
            if (state == IDLE) begin
              if (user_dat_i[12]) value1 <= user_dat_i[DAC_BITS-1:0];
              else                value0 <= user_dat_i[DAC_BITS-1:0];
            end
          end
        endcase
      end

      if (drop) dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            lat_sel    <= rate_sel_i;
            lat_rate   <= rate_i;
            lat_target <= rate_sel_i ? target1 : target0;
            state      <= CALC;
          end
        end
        CALC: begin
          if (in_band) begin
            state <= IDLE;
          end else begin
            if (lat_sel) value1 <= next_val;
            else         value0 <= next_val;
            servo_o      <= next_val;
            servo_addr_o <= lat_sel;
            servo_wr_o   <= 1'b1;
            state        <= WRITE;
          end
        end
        WRITE: begin
          servo_update_o <= 1'b1;
          state          <= UPDATE;
        end
        UPDATE: begin
          busy_cnt <= CNT_W'(BUSY_TIMEOUT - 1);
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          if (loader_busy_i) begin
            state <= WAIT_LO;
          end else if (busy_cnt == '0) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            busy_cnt <= busy_cnt - 1'b1;
          end
        end
        WAIT_LO: begin
          if (!loader_busy_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ritc_dac_servo.sv
// Directed bench for ritc_dac_servo: vector table of single servo cycles plus hand sequences for corners.
`timescale 1ns/1ps
module tb_ritc_dac_servo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rate_valid = 1'b0, rate_sel = 1'b0;
  logic [15:0] rate = '0;
  logic        user_sel = 1'b0, user_wr = 1'b0;
  logic [1:0]  user_addr = '0;
  logic [31:0] user_dat = '0, user_rd;
  logic        busy = 1'b0;
  logic        servo_addr, servo_wr, servo_update;
  logic [11:0] servo;

  int total = 0, bad = 0;
  int wr_cnt = 0, upd_cnt = 0;
  int w0, u0;
  logic [31:0] d;

  ritc_dac_servo dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .rate_valid_i(rate_valid), .rate_sel_i(rate_sel), .rate_i(rate),
    .user_sel_i(user_sel), .user_wr_i(user_wr), .user_addr_i(user_addr),
    .user_dat_i(user_dat), .user_dat_o(user_rd),
    .loader_busy_i(busy),
    .servo_addr_o(servo_addr), .servo_wr_o(servo_wr),
    .servo_update_o(servo_update), .servo_o(servo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (servo_wr === 1'b1) wr_cnt++;
    if (servo_update === 1'b1) upd_cnt++;
  end

  typedef struct {
    logic        sel;
    logic [11:0] preset;
    logic [15:0] target;
    logic [15:0] db;
    logic [11:0] step;
    logic [15:0] rate;
    logic        exp_wr;
    logic [11:0] exp_val;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    user_addr = a;
    #1;
    v = user_rd;
  endtask

  task automatic wreg(input logic [1:0] a, input logic [31:0] v);
    user_sel = 1'b1; user_wr = 1'b1; user_addr = a; user_dat = v;
    tick();
    user_sel = 1'b0; user_wr = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic [15:0] r);
    rate_valid = 1'b1; rate_sel = s; rate = r;
    tick();
    rate_valid = 1'b0; user_wr = 1'b0; user_sel = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    logic [31:0] v;
    rd(2'd0, v);
    while (v[8:6] != 3'd0 && n < 40) begin
      tick();
      rd(2'd0, v);
      n++;
    end
    check({nm, " idle"}, {29'd0, v[8:6]}, 32'd0);
  endtask

  // Accept already set up by caller; walks CALC/WRITE/UPDATE and the loader handshake.
  task automatic txn(input string nm, input logic s, input logic [15:0] r,
                     input logic exp_wr, input logic [11:0] exp_val);
    pulse(s, r);
    tick();
    check({nm, " wr"}, {31'd0, servo_wr}, {31'd0, exp_wr});
    if (exp_wr) begin
      check({nm, " val"}, {20'd0, servo}, {20'd0, exp_val});
      check({nm, " addr"}, {31'd0, servo_addr}, {31'd0, s});
    end
    tick();
    check({nm, " upd"}, {31'd0, servo_update}, {31'd0, exp_wr});
    if (exp_wr) begin
      busy = 1'b1; tick(); tick(); busy = 1'b0;
    end
    wait_idle(nm);
  endtask

  initial begin
    //         sel preset target  db   step  rate  wr  value
    vecs[0]  = '{1'b0, 12'd2048, 16'd1000,  16'd10, 12'd4,    16'd1200,  1'b1, 12'd2052};
    vecs[1]  = '{1'b0, 12'd2048, 16'd1000,  16'd10, 12'd4,    16'd1005,  1'b0, 12'd2048};
    vecs[2]  = '{1'b1, 12'd2,    16'd1000,  16'd10, 12'd4,    16'd500,   1'b1, 12'd0};
    vecs[3]  = '{1'b1, 12'd4094, 16'd1000,  16'd10, 12'd4,    16'd2000,  1'b1, 12'd4095};
    vecs[4]  = '{1'b0, 12'd100,  16'd1000,  16'd0,  12'd7,    16'd999,   1'b1, 12'd93};
    vecs[5]  = '{1'b0, 12'd500,  16'd1000,  16'd10, 12'd1,    16'd1010,  1'b0, 12'd500};
    vecs[6]  = '{1'b0, 12'd500,  16'd1000,  16'd10, 12'd1,    16'd1011,  1'b1, 12'd501};
    vecs[7]  = '{1'b1, 12'd500,  16'd1000,  16'd10, 12'd3,    16'd989,   1'b1, 12'd497};
    vecs[8]  = '{1'b0, 12'd300,  16'd0,     16'd0,  12'd5,    16'd0,     1'b0, 12'd300};
    vecs[9]  = '{1'b0, 12'd4095, 16'd65535, 16'd0,  12'd4095, 16'd0,     1'b1, 12'd0};
    vecs[10] = '{1'b1, 12'd1,    16'd0,     16'd0,  12'd4095, 16'd65535, 1'b1, 12'd4095};

    tick(); tick();
    check("rst wr", {31'd0, servo_wr}, 32'd0);
    check("rst upd", {31'd0, servo_update}, 32'd0);
    check("rst addr", {31'd0, servo_addr}, 32'd0);
    check("rst servo", {20'd0, servo}, 32'd0);
    rd(2'd0, d); check("rst reg0", d, 32'h0);
    rd(2'd1, d); check("rst reg1", d, 32'h0);
    rd(2'd2, d); check("rst reg2", d, 32'h0001_0000);
    rd(2'd3, d); check("rst reg3", d, 32'h0800_0800);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) begin
      wreg(2'd1, {vecs[i].target, vecs[i].target});
      wreg(2'd2, {4'd0, vecs[i].step, vecs[i].db});
      wreg(2'd3, {19'd0, vecs[i].sel, vecs[i].preset});
      wreg(2'd0, 32'h3);
      w0 = wr_cnt;
      txn($sformatf("vec%0d", i), vecs[i].sel, vecs[i].rate, vecs[i].exp_wr, vecs[i].exp_val);
      rd(2'd3, d);
      check($sformatf("vec%0d stored", i), {20'd0, vecs[i].sel ? d[27:16] : d[11:0]},
            {20'd0, vecs[i].exp_val});
      check($sformatf("vec%0d wr count", i), wr_cnt - w0, {31'd0, vecs[i].exp_wr});
    end

    // Target write in the accept cycle: this sample still sees target 1000.
    wreg(2'd1, {16'd1000, 16'd1000});
    wreg(2'd2, {4'd0, 12'd4, 16'd0});
    wreg(2'd3, {19'd0, 1'b0, 12'd2048});
    user_sel = 1'b1; user_wr = 1'b1; user_addr = 2'd1; user_dat = {16'd2000, 16'd2000};
    txn("old target", 1'b0, 16'd1200, 1'b1, 12'd2052);
    txn("new target", 1'b0, 16'd1200, 1'b1, 12'd2048);

    // Sample arriving during WAIT_LO is dropped.
    w0 = wr_cnt; u0 = upd_cnt;
    pulse(1'b0, 16'd3000);
    tick(); tick();
    busy = 1'b1; tick(); tick();
    rd(2'd0, d); check("in wait_lo", {29'd0, d[8:6]}, 32'd5);
    pulse(1'b0, 16'd3000);
    tick(); tick();
    busy = 1'b0;
    wait_idle("drop");
    tick(); tick(); tick();
    rd(2'd0, d); check("dropped set", {31'd0, d[4]}, 32'd1);
    check("drop wr count", wr_cnt - w0, 32'd1);
    check("drop upd count", upd_cnt - u0, 32'd1);
    wreg(2'd0, 32'h13);
    rd(2'd0, d); check("dropped w1c", d[5:0], 32'h03);

    // Preset and acceptable sample together: preset wins.
    w0 = wr_cnt;
    user_sel = 1'b1; user_wr = 1'b1; user_addr = 2'd3; user_dat = {19'd0, 1'b0, 12'd777};
    pulse(1'b0, 16'd65535);
    tick(); tick(); tick();
    check("preset wr count", wr_cnt - w0, 32'd0);
    rd(2'd3, d); check("preset value", {20'd0, d[11:0]}, 32'd777);
    rd(2'd0, d); check("preset dropped", {31'd0, d[4]}, 32'd1);
    wreg(2'd0, 32'h13);

    // Loader never goes busy: timeout after 15 WAIT_HI cycles.
    pulse(1'b0, 16'd65535);
    tick(); tick(); tick();
    rd(2'd0, d); check("wait_hi entry", {29'd0, d[8:6]}, 32'd4);
    repeat (14) tick();
    rd(2'd0, d); check("wait_hi 14", {29'd0, d[8:6]}, 32'd4);
    check("no timeout yet", {31'd0, d[5]}, 32'd0);
    tick();
    rd(2'd0, d); check("timeout state", {29'd0, d[8:6]}, 32'd0);
    check("timeout set", {31'd0, d[5]}, 32'd1);
    wreg(2'd0, 32'h23);
    rd(2'd0, d); check("timeout w1c", {31'd0, d[5]}, 32'd0);

    // Pause requested mid-cycle; paused only once back in IDLE.
    pulse(1'b0, 16'd65535);
    tick(); tick();
    busy = 1'b1; tick();
    wreg(2'd0, 32'h7);
    rd(2'd0, d); check("paused busy", {31'd0, d[3]}, 32'd0);
    tick();
    rd(2'd0, d); check("paused busy2", {31'd0, d[3]}, 32'd0);
    busy = 1'b0; tick();
    rd(2'd0, d); check("paused idle", {31'd0, d[3]}, 32'd1);
    w0 = wr_cnt;
    pulse(1'b0, 16'd65535);
    tick(); tick(); tick();
    check("paused wr count", wr_cnt - w0, 32'd0);
    rd(2'd0, d); check("paused no drop", {31'd0, d[4]}, 32'd0);
    wreg(2'd0, 32'h0);
    pulse(1'b1, 16'd65535);
    tick(); tick(); tick();
    check("disabled wr count", wr_cnt - w0, 32'd0);
    rd(2'd0, d); check("disabled no drop", {31'd0, d[4]}, 32'd0);

    // Reset while in CALC aborts without strobes and restores defaults.
    wreg(2'd0, 32'h3);
    w0 = wr_cnt;
    pulse(1'b0, 16'd65535);
    rst_n = 1'b0;
    tick();
    check("abort wr", {31'd0, servo_wr}, 32'd0);
    rd(2'd0, d); check("abort reg0", d, 32'h0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("abort wr count", wr_cnt - w0, 32'd0);
    rd(2'd3, d); check("abort reg3", d, 32'h0800_0800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
